// File: rtl/xpt2046_pkg.sv
// ---------------------------------------------------------------------------
// xpt2046_pkg
// Shared definitions for the XPT2046 touch-controller emulator:
//   - default channel codes answered with the X, Y and Z1 sample inputs
//   - control-byte layout (S=7, A=6:4, MODE=3, SER/DFR=2, PD=1:0)
//   - command-engine state encoding and frame length constants
//   - helpers that build the output shift word and (optionally) add noise
// Optional feature macro: XPT_EMU_NOISE_EN (enables the noise helper).
// ---------------------------------------------------------------------------
package xpt2046_pkg;

    localparam logic [2:0] CH_X  = 3'b101;
    localparam logic [2:0] CH_Y  = 3'b001;
    localparam logic [2:0] CH_Z1 = 3'b011;

    localparam int CMD_BITS = 8;    // control byte length, start bit included
    localparam int SAMPLE_W = 12;   // conversion result width
    localparam int DOUT_W   = 16;   // output shift register width

    // Control byte, MSB first: S, A2..A0, MODE, SER/DFR, PD1..PD0.
    typedef struct packed {
        logic       start;
        logic [2:0] addr;
        logic       mode;
        logic       ser_dfr;
        logic [1:0] pd;
    } xpt_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_BUSY = 2'd2
    } xpt_state_e;

    // MODE=0 shifts out 12 bits, MODE=1 only the top 8; the rest is zero fill.
    function automatic logic [DOUT_W-1:0] dout_word(input logic [SAMPLE_W-1:0] sample,
                                                    input logic                mode);
        if (mode)
            return {sample[11:4], 8'h00};
        else
            return {sample, 4'h0};
    endfunction

`ifdef XPT_EMU_NOISE_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Adds a signed -4..+3 offset and clamps to the 12-bit conversion range.
    function automatic logic [SAMPLE_W-1:0] add_noise(input logic [SAMPLE_W-1:0] sample,
                                                      input logic [2:0]          noise);
        logic signed [13:0] sum;
        sum = $signed({2'b00, sample}) + $signed({{11{noise[2]}}, noise});
        if (sum < 14'sd0)
            return 12'h000;
        else if (sum > 14'sd4095)
            return 12'hFFF;
        else
            return sum[11:0];
    endfunction
`endif

endpackage

// File: rtl/xpt_sync_edge.sv
// ---------------------------------------------------------------------------
// xpt_sync_edge
// Two-flop synchronizer for an asynchronous SPI pin, followed by a registered
// rise/fall detector.
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : raw pin
//   level      : synchronized level (2 clk after the pin)
//   rise, fall : one-clk pulses, 3 clk after the pin edge
// RST_VAL is the idle level of the pin so that reset release does not
// produce a spurious edge.
// ---------------------------------------------------------------------------
module xpt_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       rise_reg;
    logic       fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {2{RST_VAL}};
            prev_reg <= RST_VAL;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], async_in};
            prev_reg <= sync_reg[1];
            rise_reg <= sync_reg[1] & ~prev_reg;
            fall_reg <= ~sync_reg[1] & prev_reg;
        end
    end

    assign level = sync_reg[1];
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/xpt2046_emu.sv
// ---------------------------------------------------------------------------
// xpt2046_emu
// SPI responder that behaves like an XPT2046 touch controller so that a
// touch-controller master can be exercised without a panel.
//   clk, rst_n           : system clock, asynchronous active-low reset
//   spi_cs_n/sclk/mosi   : SPI pins from the master (asynchronous)
//   spi_miso, _oe        : DOUT and its output enable (enable only while CS low)
//   pen_irq_n            : PENIRQ, registered inverse of touch_pressed
//   touch_pressed        : 1 = panel touched
//   x_val, y_val, z_val  : samples returned for the X, Y and Z1 channels
//   conv_pulse           : one-clk pulse per accepted control byte
//   last_cmd             : most recent complete control byte
//   conv_count           : accepted-command counter (wraps)
// Optional feature macro: XPT_EMU_NOISE_EN adds LFSR noise (-4..+3, clamped)
// to each snapshot sample; without it samples are returned unchanged.
// ---------------------------------------------------------------------------
module xpt2046_emu
    import xpt2046_pkg::*;
#(
    parameter logic [2:0] X_CH  = CH_X,
    parameter logic [2:0] Y_CH  = CH_Y,
    parameter logic [2:0] Z1_CH = CH_Z1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        pen_irq_n,
    input  logic        touch_pressed,
    input  logic [11:0] x_val,
    input  logic [11:0] y_val,
    input  logic [11:0] z_val,
    output logic        conv_pulse,
    output logic [7:0]  last_cmd,
    output logic [15:0] conv_count
);

    // ---------------- input conditioning ----------------
    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [1:0] mosi_sync_reg;
    logic       mosi_s;

    xpt_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi_sclk),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    xpt_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi_cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Only the SCLK edges and the CS level drive the logic.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_rise, cs_fall};

    // MOSI only needs a level; it is stable for many clk around each rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mosi_sync_reg <= 2'b00;
        else
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
    end
    assign mosi_s = mosi_sync_reg[1];

    // ---------------- command engine ----------------
    xpt_state_e state_reg, state_next;
    logic [2:0] bitcnt_reg, bitcnt_next;
    logic [7:0] cmd_sr_reg, cmd_sr_next;
    xpt_cmd_t   cmd_byte;       // cmd_sr with the current MOSI bit merged in
    logic       cmd_done;       // 8th rise: control byte complete
    logic       busy_load;      // BUSY rise: load the output shift register

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            bitcnt_reg <= 3'd0;
            cmd_sr_reg <= 8'h00;
        end else begin
            state_reg  <= state_next;
            bitcnt_reg <= bitcnt_next;
            cmd_sr_reg <= cmd_sr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bitcnt_next = bitcnt_reg;
        cmd_sr_next = cmd_sr_reg;
        cmd_done    = 1'b0;
        busy_load   = 1'b0;
        // Bits land at their final position, so the byte is complete on the
        // 8th rise without a trailing shift.
        cmd_byte    = cmd_sr_reg;
        cmd_byte[3'd7 - bitcnt_reg] = mosi_s;

        if (cs_level) begin
            state_next  = ST_IDLE;
            bitcnt_next = 3'd0;
        end else if (sclk_rise) begin
            case (state_reg)
                ST_IDLE: begin
                    if (mosi_s) begin
                        state_next  = ST_CMD;
                        bitcnt_next = 3'd1;
                        cmd_sr_next = 8'h80;
                    end
                end
                ST_CMD: begin
                    cmd_sr_next = cmd_byte;
                    if (bitcnt_reg == 3'(CMD_BITS - 1)) begin
                        cmd_done    = 1'b1;
                        bitcnt_next = 3'd0;
                        state_next  = ST_BUSY;
                    end else begin
                        bitcnt_next = bitcnt_reg + 3'd1;
                    end
                end
                ST_BUSY: begin
                    // MOSI is ignored here; a new start bit is only
                    // recognised from IDLE on a later rise.
                    busy_load  = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- sample selection ----------------
    logic [SAMPLE_W-1:0] sample_sel;
    logic [SAMPLE_W-1:0] sample_next;

    always_comb begin
        sample_sel = 12'h000;
        if (cmd_byte.addr == X_CH)
            sample_sel = x_val;
        else if (cmd_byte.addr == Y_CH)
            sample_sel = y_val;
        else if (cmd_byte.addr == Z1_CH)
            sample_sel = z_val;
    end

`ifdef XPT_EMU_NOISE_EN
    logic [15:0] lfsr_reg;

    // Fibonacci LFSR, taps 16,15,13,4; one step per accepted command. The
    // current value's low bits are used before stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr_reg <= LFSR_SEED;
        else if (cmd_done)
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3]};
    end

    assign sample_next = add_noise(sample_sel, lfsr_reg[2:0]);
`else
    assign sample_next = sample_sel;
`endif

    // ---------------- datapath / outputs ----------------
    logic [SAMPLE_W-1:0] snapshot_reg;
    logic                mode_reg;
    xpt_cmd_t            last_cmd_reg;
    logic [15:0]         conv_count_reg;
    logic                conv_pulse_reg;
    logic [DOUT_W-1:0]   dout_sr_reg;
    logic                miso_reg;
    logic                miso_oe_reg;
    logic                pen_irq_n_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot_reg   <= '0;
            mode_reg       <= 1'b0;
            last_cmd_reg   <= '0;
            conv_count_reg <= 16'd0;
            conv_pulse_reg <= 1'b0;
            dout_sr_reg    <= '0;
            miso_reg       <= 1'b0;
            miso_oe_reg    <= 1'b0;
            pen_irq_n_reg  <= 1'b1;
        end else begin
            conv_pulse_reg <= cmd_done;
            pen_irq_n_reg  <= ~touch_pressed;
            miso_oe_reg    <= ~cs_level;

            if (cmd_done) begin
                last_cmd_reg   <= cmd_byte;
                conv_count_reg <= conv_count_reg + 16'd1;
                snapshot_reg   <= sample_next;
                mode_reg       <= cmd_byte.mode;
            end

            // Counter, last_cmd and snapshot survive CS high; the shifter
            // does not. A BUSY load may interrupt a word still shifting out.
            if (cs_level) begin
                dout_sr_reg <= '0;
                miso_reg    <= 1'b0;
            end else if (busy_load) begin
                dout_sr_reg <= dout_word(snapshot_reg, mode_reg);
            end else if (sclk_fall) begin
                miso_reg    <= dout_sr_reg[DOUT_W-1];
                dout_sr_reg <= {dout_sr_reg[DOUT_W-2:0], 1'b0};
            end
        end
    end

    assign spi_miso    = miso_reg;
    assign spi_miso_oe = miso_oe_reg;
    assign pen_irq_n   = pen_irq_n_reg;
    assign conv_pulse  = conv_pulse_reg;
    assign last_cmd    = last_cmd_reg;
    assign conv_count  = conv_count_reg;

endmodule

// File: tb/tb_xpt2046_emu.sv
// ---------------------------------------------------------------------------
// tb_xpt2046_emu
// Drives SPI frames like a touch-controller master and checks the emulator
// through two queues: expected data words and expected command records are
// queued when a frame is issued; monitors pop them when the master has
// collected a word or when conv_pulse fires.
// ---------------------------------------------------------------------------
module tb_xpt2046_emu;

    localparam int HALF = 8;   // clk cycles per SCLK phase

    logic        clk;
    logic        rst_n;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        pen_irq_n;
    logic        touch_pressed;
    logic [11:0] x_val;
    logic [11:0] y_val;
    logic [11:0] z_val;
    logic        conv_pulse;
    logic [7:0]  last_cmd;
    logic [15:0] conv_count;

    xpt2046_emu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_cs_n      (spi_cs_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .pen_irq_n     (pen_irq_n),
        .touch_pressed (touch_pressed),
        .x_val         (x_val),
        .y_val         (y_val),
        .z_val         (z_val),
        .conv_pulse    (conv_pulse),
        .last_cmd      (last_cmd),
        .conv_count    (conv_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [11:0] sample;
        logic        mode;
    } exp_t;

    exp_t        exp_q[$];
    logic [14:0] rx_q[$];
    logic [23:0] conv_q[$];     // {command byte, expected count}
    logic [15:0] model_count;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Reference: which input a channel code selects.
    function automatic logic [11:0] chan_value(input logic [7:0] cmd);
        case (cmd[6:4])
            3'b101:  return x_val;
            3'b001:  return y_val;
            3'b011:  return z_val;
            default: return 12'h000;
        endcase
    endfunction

    // 15 bits seen at rises 10..24: the result MSB first, then zeros.
    function automatic logic [14:0] word_of(input exp_t e);
        if (e.mode)
            return {e.sample[11:4], 7'b0};
        else
            return {e.sample, 3'b0};
    endfunction

    task automatic issue(input logic [7:0] cmd, input bit data_expected);
        exp_t e;
        model_count = model_count + 16'd1;
        conv_q.push_back({cmd, model_count});
        if (data_expected) begin
            e.sample = chan_value(cmd);
            e.mode   = cmd[3];
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_conv
        logic [23:0] c;
        if (conv_pulse === 1'b1) begin
            if (conv_q.size() == 0) begin
                checks++;
                $display("FAIL conv_unexpected: got pulse, expected none (last_cmd %0h)", last_cmd);
            end else begin
                c = conv_q.pop_front();
                check("last_cmd", {24'd0, last_cmd}, {24'd0, c[23:16]});
                check("conv_count", {16'd0, conv_count}, {16'd0, c[15:0]});
            end
        end
    end

    always @(negedge clk) begin : mon_data
        logic [14:0] w;
        exp_t        e;
        int          lo, hi, got;
        if (rx_q.size() > 0) begin
            w = rx_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL data_unexpected: got %0h, expected no word", w);
            end else begin
                e = exp_q.pop_front();
`ifdef XPT_EMU_NOISE_EN
                lo = (int'(e.sample) - 4 < 0) ? 0 : int'(e.sample) - 4;
                hi = (int'(e.sample) + 3 > 4095) ? 4095 : int'(e.sample) + 3;
                checks++;
                if (e.mode) begin
                    got = int'(w[14:7]);
                    if (got >= (lo >> 4) && got <= (hi >> 4) && w[6:0] == 7'd0)
                        passes++;
                    else
                        $display("FAIL data_noisy8: got %0h, expected %0h..%0h", w, lo >> 4, hi >> 4);
                end else begin
                    got = int'(w[14:3]);
                    if (got >= lo && got <= hi && w[2:0] == 3'd0)
                        passes++;
                    else
                        $display("FAIL data_noisy12: got %0h, expected %0h..%0h", w, lo, hi);
                end
`else
                lo = 0; hi = 0; got = 0;
                check("data_word", {17'd0, w}, {17'd0, word_of(e)});
`endif
            end
        end
    end

    // ---------------- SPI master ----------------
    task automatic sclk_bit(input bit b, output bit r);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        r = spi_miso;               // master samples DOUT at the rise
        spi_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    // Commands placed every 'period' rises, 16 trailing rises after the last.
    task automatic run_frame(input logic [7:0] cmds[$], input int period, input bit busy_one);
        int          n;
        int          len;
        bit          stream[$];
        bit          rxb[$];
        bit          r;
        logic [14:0] w;
        n   = cmds.size();
        len = (n - 1) * period + 24;
        for (int i = 0; i < len; i++) stream.push_back(1'b0);
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++)
                stream[k * period + b] = cmds[k][7 - b];
        if (busy_one) stream[(n - 1) * period + 8] = 1'b1;
        for (int k = 0; k < n; k++) issue(cmds[k], 1'b1);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
        for (int i = 0; i < len; i++) begin
            sclk_bit(stream[i], r);
            rxb.push_back(r);
        end
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 15; j++) w[14 - j] = rxb[k * period + 9 + j];
            rx_q.push_back(w);
        end
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("oe_after_cs", {31'd0, spi_miso_oe}, 32'd0);
        check("miso_after_cs", {31'd0, spi_miso}, 32'd0);
    endtask

    // Shifts 'rises' bits of cmd followed by zeros, then leaves CS as is.
    task automatic partial_frame(input logic [7:0] cmd, input int rises);
        bit r;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < rises; i++)
            sclk_bit((i < 8) ? cmd[7 - i] : 1'b0, r);
    endtask

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [7:0] cmds[$];
        logic [6:0] r7;
        int         n, period;

        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        touch_pressed = 1'b0; x_val = '0; y_val = '0; z_val = '0;
        model_count = 16'd0;
        repeat (4) @(negedge clk);
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("rst_penirq", {31'd0, pen_irq_n}, 32'd1);
        check("rst_conv_pulse", {31'd0, conv_pulse}, 32'd0);
        check("rst_last_cmd", {24'd0, last_cmd}, 32'd0);
        check("rst_conv_count", {16'd0, conv_count}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // X in 12-bit mode, Y, X in 8-bit mode
        x_val = 12'hABC; y_val = 12'h123; z_val = 12'h5A5;
        cmds = {8'hD0}; run_frame(cmds, 15, 1'b0);
        check("last_cmd_d0", {24'd0, last_cmd}, 32'hD0);
        check("count_after_first", {16'd0, conv_count}, 32'd1);
        cmds = {8'h90}; run_frame(cmds, 15, 1'b1);
        cmds = {8'hD8}; run_frame(cmds, 15, 1'b0);
        cmds = {8'hB4}; run_frame(cmds, 15, 1'b0);   // Z1 channel
        cmds = {8'hA0}; run_frame(cmds, 15, 1'b0);   // unmapped channel

        // 10 chained X/Y commands at 15-clock spacing
        x_val = 12'(($urandom)); y_val = 12'(($urandom));
        cmds = {};
        for (int k = 0; k < 10; k++) cmds.push_back((k % 2) ? 8'h90 : 8'hD0);
        run_frame(cmds, 15, 1'b0);
        check("count_after_chain", {16'd0, conv_count}, {16'd0, model_count});

        // CS raised after rise 14, then a fresh Y frame
        issue(8'h90, 1'b0);
        partial_frame(8'h90, 14);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("oe_between_frames", {31'd0, spi_miso_oe}, 32'd0);
        check("miso_between_frames", {31'd0, spi_miso}, 32'd0);
        cmds = {8'h90}; run_frame(cmds, 15, 1'b0);

        // PENIRQ follows touch_pressed with one registered stage
        touch_pressed = 1'b1;
        #1 check("pen_before_edge", {31'd0, pen_irq_n}, 32'd1);
        @(negedge clk) check("pen_pressed", {31'd0, pen_irq_n}, 32'd0);
        repeat (3) @(negedge clk);
        touch_pressed = 1'b0;
        #1 check("pen_hold", {31'd0, pen_irq_n}, 32'd0);
        @(negedge clk) check("pen_released", {31'd0, pen_irq_n}, 32'd1);

        // Reset mid-data
        touch_pressed = 1'b1;
        issue(8'hD0, 1'b0);
        partial_frame(8'hD0, 15);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {31'd0, spi_miso}, 32'd0);
        check("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
        check("midrst_penirq", {31'd0, pen_irq_n}, 32'd1);
        check("midrst_conv_pulse", {31'd0, conv_pulse}, 32'd0);
        check("midrst_last_cmd", {24'd0, last_cmd}, 32'd0);
        check("midrst_conv_count", {16'd0, conv_count}, 32'd0);
        spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; touch_pressed = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_count = 16'd0;
        repeat (4) @(negedge clk);
        cmds = {8'hD0}; run_frame(cmds, 15, 1'b0);
        check("count_after_reset", {16'd0, conv_count}, 32'd1);

        // Randomized frames
        for (int it = 0; it < 12; it++) begin
            x_val = 12'($urandom); y_val = 12'($urandom); z_val = 12'($urandom);
            n      = $urandom_range(1, 3);
            period = $urandom_range(15, 20);
            cmds = {};
            for (int k = 0; k < n; k++) begin
                r7 = 7'($urandom);
                cmds.push_back({1'b1, r7});
            end
            run_frame(cmds, period, 1'($urandom));
        end

`ifdef XPT_EMU_NOISE_EN
        x_val = 12'd2048;
        for (int it = 0; it < 20; it++) begin
            cmds = {8'hD0}; run_frame(cmds, 15, 1'b0);
        end
        x_val = 12'd0;
        for (int it = 0; it < 8; it++) begin
            cmds = {8'hD0}; run_frame(cmds, 15, 1'b0);
        end
`endif

        repeat (10) @(negedge clk);
        check("data_queue_drained", exp_q.size(), 32'd0);
        check("conv_queue_drained", conv_q.size(), 32'd0);
        check("final_count", {16'd0, conv_count}, {16'd0, model_count});
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
